// File: rtl/alarma_amanecer_fsm.sv
// rtl/alarma_amanecer_fsm.sv - multi-channel sunrise alarm with stepped brightness ramp and snooze
module alarma_amanecer_fsm #(
    parameter int N_ALARMAS  = 4,
    parameter int CLK_HZ     = 50_000_000,
    parameter int RAMP_STEPS = 8,
    parameter int STEP_SEC   = 10,
    parameter int DUTY_MAX   = 50000,
    parameter int SNOOZE_SEC = 300,
    localparam int CW = (N_ALARMAS > 1) ? $clog2(N_ALARMAS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [23:0]             Hora_actual,
    input  logic [24*N_ALARMAS-1:0] Hora_alarma,
    input  logic [N_ALARMAS-1:0]    habilitar,
    input  logic                    sensores,
    input  logic                    posponer,
    output logic                    Activada,
    output logic                    Sonando,
    output logic                    Pospuesta,
    output logic [CW-1:0]           canal,
    output logic [1:0]              accion,
    output logic [15:0]             dutty
);

    localparam int          TW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [16:0] DUTY_STEP = 17'(DUTY_MAX / RAMP_STEPS);
    localparam logic [6:0]  LAST_STEP = 7'(RAMP_STEPS - 1);
    localparam logic [1:0]  ACC_LOAD  = 2'b10;
    localparam logic [1:0]  ACC_OFF   = 2'b01;

    typedef enum logic [1:0] {
        DESACTIVADA,
        ACTIVADA,
        SONANDO,
        POSPUESTA
    } state_t;

    state_t                 state, state_n;
    logic [TW-1:0]          tick_cnt;
    logic                   tick;
    logic [N_ALARMAS-1:0]   match, fire, prev_match;
    logic [CW-1:0]          fire_idx;
    logic [CW-1:0]          canal_n;
    logic [6:0]             step, step_n;
    logic [7:0]             sec_cnt, sec_n;
    logic [11:0]            snz_cnt, snz_n;
    logic [15:0]            dutty_n;
    logic [1:0]             accion_n;
    logic                   dismiss;

    // The final step is pinned to DUTY_MAX so integer division never leaves the lamp short.
    function automatic logic [15:0] duty_of(input logic [6:0] s);
        logic [16:0] prod;
        prod = DUTY_STEP * {10'd0, s + 7'd1};
        if (s == LAST_STEP)
            return 16'(DUTY_MAX);
        else
            return 16'(prod);
    endfunction

    assign tick = (tick_cnt == TW'(CLK_HZ - 1));

    always_ff @(posedge clk) begin
        if (rst || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < N_ALARMAS; i++)
            match[i] = habilitar[i] && (Hora_actual == Hora_alarma[24*i +: 24]);
    end

    assign fire = match & ~prev_match;

    always_comb begin
        fire_idx = '0;
        for (int i = N_ALARMAS - 1; i >= 0; i--)
            if (fire[i])
                fire_idx = CW'(i);
    end

    assign dismiss = sensores || !habilitar[canal];

    always_comb begin
        state_n  = state;
        canal_n  = canal;
        step_n   = step;
        sec_n    = sec_cnt;
        snz_n    = snz_cnt;
        dutty_n  = dutty;
        accion_n = 2'b00;
        case (state)
            DESACTIVADA: begin
                if (|habilitar)
                    state_n = ACTIVADA;
            end
            ACTIVADA: begin
                if (habilitar == '0) begin
                    state_n = DESACTIVADA;
                end else if (|fire) begin
                    state_n  = SONANDO;
                    canal_n  = fire_idx;
                    step_n   = '0;
                    sec_n    = '0;
                    dutty_n  = duty_of(7'd0);
                    accion_n = ACC_LOAD;
                end
            end
            SONANDO: begin
                if (dismiss) begin
                    state_n  = (|habilitar) ? ACTIVADA : DESACTIVADA;
                    dutty_n  = '0;
                    accion_n = ACC_OFF;
                end else if (posponer) begin
                    state_n  = POSPUESTA;
                    dutty_n  = '0;
                    accion_n = ACC_OFF;
                    snz_n    = '0;
                end else if (tick) begin
                    if ({1'b0, sec_cnt} + 9'd1 == 9'(STEP_SEC)) begin
                        sec_n = '0;
                        if (step != LAST_STEP) begin
                            step_n   = step + 7'd1;
                            dutty_n  = duty_of(step + 7'd1);
                            accion_n = ACC_LOAD;
                        end
                    end else begin
                        sec_n = sec_cnt + 8'd1;
                    end
                end
            end
            POSPUESTA: begin
                if (dismiss) begin
                    state_n  = (|habilitar) ? ACTIVADA : DESACTIVADA;
                    dutty_n  = '0;
                    accion_n = ACC_OFF;
                end else if (tick) begin
                    if ({1'b0, snz_cnt} + 13'd1 == 13'(SNOOZE_SEC)) begin
                        state_n  = SONANDO;
                        step_n   = '0;
                        sec_n    = '0;
                        dutty_n  = duty_of(7'd0);
                        accion_n = ACC_LOAD;
                    end else begin
                        snz_n = snz_cnt + 12'd1;
                    end
                end
            end
            default: state_n = DESACTIVADA;
        endcase
    end

    // prev_match powers up as all ones so a match already present at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DESACTIVADA;
            prev_match <= '1;
            canal      <= '0;
            step       <= '0;
            sec_cnt    <= '0;
            snz_cnt    <= '0;
            dutty      <= '0;
            accion     <= 2'b00;
            Activada   <= 1'b0;
            Sonando    <= 1'b0;
            Pospuesta  <= 1'b0;
        end else begin
            state      <= state_n;
            prev_match <= match;
            canal      <= canal_n;
            step       <= step_n;
            sec_cnt    <= sec_n;
            snz_cnt    <= snz_n;
            dutty      <= dutty_n;
            accion     <= accion_n;
            Activada   <= (state_n == ACTIVADA);
            Sonando    <= (state_n == SONANDO);
            Pospuesta  <= (state_n == POSPUESTA);
        end
    end

endmodule

// File: tb/tb_alarma_amanecer_fsm.sv
// tb/tb_alarma_amanecer_fsm.sv - directed bench for alarma_amanecer_fsm
module tb_alarma_amanecer_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] Hora_actual;
    logic [95:0] Hora_alarma;
    logic [3:0]  habilitar;
    logic        sensores;
    logic        posponer;
    logic        Activada, Sonando, Pospuesta;
    logic [1:0]  canal;
    logic [1:0]  accion;
    logic [15:0] dutty;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n;

    alarma_amanecer_fsm #(
        .N_ALARMAS (4),
        .CLK_HZ    (4),
        .RAMP_STEPS(4),
        .STEP_SEC  (2),
        .DUTY_MAX  (40000),
        .SNOOZE_SEC(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Hora_actual(Hora_actual),
        .Hora_alarma(Hora_alarma),
        .habilitar  (habilitar),
        .sensores   (sensores),
        .posponer   (posponer),
        .Activada   (Activada),
        .Sonando    (Sonando),
        .Pospuesta  (Pospuesta),
        .canal      (canal),
        .accion     (accion),
        .dutty      (dutty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_act(input int max, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (accion == 2'b00 && cnt < max);
    endtask

    task automatic align();
        while (cyc % 4 != 0)
            step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        Hora_actual = 24'h000000;
        Hora_alarma = {24'h081500, 24'h120000, 24'h081500, 24'h073000};
        habilitar   = 4'b0000;
        sensores    = 1'b0;
        posponer    = 1'b0;
        step();
        step();
        chk("rst_activada", Activada, 0);
        chk("rst_sonando", Sonando, 0);
        chk("rst_pospuesta", Pospuesta, 0);
        chk("rst_canal", canal, 0);
        chk("rst_accion", accion, 0);
        chk("rst_dutty", dutty, 0);
        rst = 1'b0;
        cyc = 0;

        // Basic fire and full ramp
        habilitar = 4'b0001;
        step();
        chk("arm_activada", Activada, 1);
        align();
        Hora_actual = 24'h073000;
        step();
        chk("fire_sonando", Sonando, 1);
        chk("fire_canal", canal, 0);
        chk("fire_dutty", dutty, 10000);
        chk("fire_accion", accion, 2'b10);
        step();
        chk("fire_pulse_end", accion, 0);
        chk("fire_dutty_hold", dutty, 10000);
        wait_act(20, n);
        chk("ramp1_delay", n, 6);
        chk("ramp1_dutty", dutty, 20000);
        chk("ramp1_accion", accion, 2'b10);
        wait_act(20, n);
        chk("ramp2_delay", n, 8);
        chk("ramp2_dutty", dutty, 30000);
        wait_act(20, n);
        chk("ramp3_delay", n, 8);
        chk("ramp3_dutty", dutty, 40000);
        wait_act(20, n);
        chk("sat_no_pulse", n, 20);
        chk("sat_dutty", dutty, 40000);
        sensores = 1'b1;
        step();
        sensores = 1'b0;
        chk("dismiss_activada", Activada, 1);
        chk("dismiss_dutty", dutty, 0);
        chk("dismiss_accion", accion, 2'b01);
        step();
        chk("dismiss_pulse_end", accion, 0);

        // Lowest channel wins; dismissal inside the matching second does not re-fire
        habilitar   = 4'b1011;
        Hora_actual = 24'h081500;
        step();
        chk("prio_sonando", Sonando, 1);
        chk("prio_canal", canal, 1);
        chk("prio_dutty", dutty, 10000);
        sensores = 1'b1;
        step();
        sensores = 1'b0;
        chk("prio_dismiss_activada", Activada, 1);
        chk("prio_dismiss_accion", accion, 2'b01);
        chk("prio_canal_hold", canal, 1);
        for (int i = 0; i < 6; i++)
            step();
        chk("prio_no_refire", Sonando, 0);
        chk("prio_still_activada", Activada, 1);

        // Snooze
        Hora_actual = 24'h000000;
        habilitar   = 4'b0001;
        step();
        align();
        Hora_actual = 24'h073000;
        step();
        chk("snz_fire_sonando", Sonando, 1);
        wait_act(20, n);
        chk("snz_ramp_delay", n, 7);
        chk("snz_ramp_dutty", dutty, 20000);
        step();
        step();
        step();
        chk("snz_pre_dutty", dutty, 20000);
        posponer = 1'b1;
        step();
        posponer = 1'b0;
        chk("snz_pospuesta", Pospuesta, 1);
        chk("snz_dutty", dutty, 0);
        chk("snz_accion", accion, 2'b01);
        wait_act(20, n);
        chk("snz_len", n, 12);
        chk("snz_resume_sonando", Sonando, 1);
        chk("snz_resume_dutty", dutty, 10000);
        chk("snz_resume_accion", accion, 2'b10);
        chk("snz_resume_canal", canal, 0);

        // Dismiss beats snooze; enable removal while snoozed
        sensores = 1'b1;
        posponer = 1'b1;
        step();
        sensores = 1'b0;
        posponer = 1'b0;
        chk("coll_activada", Activada, 1);
        chk("coll_pospuesta", Pospuesta, 0);
        chk("coll_accion", accion, 2'b01);
        Hora_actual = 24'h000000;
        step();
        Hora_actual = 24'h073000;
        step();
        chk("coll_refire", Sonando, 1);
        posponer = 1'b1;
        step();
        posponer = 1'b0;
        chk("coll_snoozed", Pospuesta, 1);
        habilitar = 4'b0000;
        step();
        chk("enrm_activada", Activada, 0);
        chk("enrm_pospuesta", Pospuesta, 0);
        chk("enrm_accion", accion, 2'b01);
        chk("enrm_dutty", dutty, 0);

        // Reset mid-ramp, then release inside a matching second
        habilitar   = 4'b0001;
        Hora_actual = 24'h000000;
        step();
        chk("rr_activada", Activada, 1);
        Hora_actual = 24'h073000;
        step();
        chk("rr_sonando", Sonando, 1);
        rst = 1'b1;
        step();
        chk("rr_sonando_off", Sonando, 0);
        chk("rr_dutty", dutty, 0);
        chk("rr_accion", accion, 0);
        chk("rr_canal", canal, 0);
        step();
        rst = 1'b0;
        cyc = 0;
        step();
        chk("rr_rearm", Activada, 1);
        for (int i = 0; i < 3; i++)
            step();
        chk("rr_no_fire", Sonando, 0);
        chk("rr_no_accion", accion, 0);

        // Disabled channels never arm or fire
        habilitar = 4'b0000;
        step();
        chk("gate_off", Activada, 0);
        Hora_actual = 24'h000000;
        step();
        Hora_actual = 24'h073000;
        step();
        chk("gate_activada", Activada, 0);
        chk("gate_sonando", Sonando, 0);
        habilitar = 4'b0100;
        step();
        chk("gate_arm", Activada, 1);
        chk("gate_no_fire", Sonando, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
